mem32_arb_ctrl: RTL and testbench

MEM32_ARB_CTRL -- requirements
Module: mem32_arb_ctrl

---
 rtl/mem32_pkg.sv | 36 +++
 rtl/mem32_arb_ctrl_rr_arb2.sv | 20 ++
 rtl/mem32_arb_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_mem32_arb_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem32_pkg.sv
// mem32_pkg: shared types and constants for the mem32 arbitrated controller.
package mem32_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_CAP   = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Bytes per assembled read word.
    localparam int unsigned NUM_BYTES = 4;

    // Default number of WRITE cycles allowed before a write is declared failed.
    localparam int unsigned DEFAULT_TIMEOUT = 8;

    // Insert byte 'b' at big-endian position 'idx' (0 = most significant).
    function automatic logic [31:0] put_byte(
        input logic [31:0] word,
        input logic [1:0]  idx,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = word;
        case (idx)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem32_arb_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter. A lone request always wins; on a tie
// the requester that was not served last wins. Purely combinational.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    // Pick one requester, favouring the one not served last on a tie.
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem32_arb_ctrl.sv
// mem32_arb_ctrl: serves two requesters round-robin against a memory with a
// word-wide write port (completion flag) and a byte-wide read port. Reads are
// assembled big-endian from four byte accesses. Every output is registered.
module mem32_arb_ctrl
    import mem32_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        op0,
    input  logic        op1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata,
    output logic        err,
    output logic        m_wr,
    output logic        m_rd,
    output logic [1:0]  m_addr,
    output logic [31:0] m_indata,
    input  logic [7:0]  m_dataout,
    input  logic        m_valid
);

    localparam int unsigned    CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  WLAST = CW'(TIMEOUT - 1);
    localparam logic [1:0]     KLAST = 2'(NUM_BYTES - 1);

    // Registered state and outputs.
    state_t        r_state;
    logic [1:0]    r_k;
    logic [CW-1:0] r_wcnt;
    logic          r_last;
    logic [31:0]   r_rbuf;
    logic [1:0]    r_gnt;
    logic [1:0]    r_done;
    logic          r_err;
    logic [31:0]   r_rdata;
    logic          r_m_wr;
    logic          r_m_rd;
    logic [1:0]    r_m_addr;
    logic [31:0]   r_m_indata;

    // Next-cycle values.
    state_t        w_nxt_state;
    logic [1:0]    w_nxt_k;
    logic [CW-1:0] w_nxt_wcnt;
    logic          w_nxt_last;
    logic [31:0]   w_nxt_rbuf;
    logic [1:0]    w_nxt_gnt;
    logic [1:0]    w_nxt_done;
    logic          w_nxt_err;
    logic [31:0]   w_nxt_rdata;
    logic          w_nxt_m_wr;
    logic          w_nxt_m_rd;
    logic [1:0]    w_nxt_m_addr;
    logic [31:0]   w_nxt_m_indata;

    logic [1:0]    w_req;
    logic [1:0]    w_arb_gnt;
    logic          w_sel_op;
    logic [31:0]   w_sel_wdata;
    logic [31:0]   w_cap;

    assign w_req       = {req1, req0};
    assign w_sel_op    = w_arb_gnt[1] ? op1    : op0;
    assign w_sel_wdata = w_arb_gnt[1] ? wdata1 : wdata0;
    assign w_cap       = put_byte(r_rbuf, r_k, m_dataout);

    rr_arb2 u_arb (
        .i_req  (w_req),
        .i_last (r_last),
        .o_gnt  (w_arb_gnt)
    );

    // Next-state and next-output decode; outputs are computed one cycle ahead
    // so that they can be registered and still line up with the state.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_k        = r_k;
        w_nxt_wcnt     = r_wcnt;
        w_nxt_last     = r_last;
        w_nxt_rbuf     = r_rbuf;
        w_nxt_gnt      = r_gnt;
        w_nxt_done     = 2'b00;
        w_nxt_err      = 1'b0;
        w_nxt_rdata    = '0;
        w_nxt_m_wr     = 1'b0;
        w_nxt_m_rd     = 1'b0;
        w_nxt_m_addr   = '0;
        w_nxt_m_indata = '0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_arb_gnt != 2'b00) begin
                    w_nxt_gnt  = w_arb_gnt;
                    w_nxt_k    = '0;
                    w_nxt_wcnt = '0;
                    w_nxt_rbuf = '0;
                    if (w_sel_op) begin
                        w_nxt_state = ST_RD_ISSUE;
                        w_nxt_m_rd  = 1'b1;
                    end else begin
                        w_nxt_state    = ST_WRITE;
                        w_nxt_m_wr     = 1'b1;
                        w_nxt_m_indata = w_sel_wdata;
                    end
                end
            end

            ST_WRITE: begin
                w_nxt_m_wr     = 1'b1;
                w_nxt_m_indata = r_m_indata;
                // The flag seen at the end of the first WRITE cycle may be
                // left over from a previous write, so it is not trusted.
                if ((r_wcnt != '0) && m_valid) begin
                    w_nxt_state    = ST_DONE;
                    w_nxt_done     = r_gnt;
                    w_nxt_m_wr     = 1'b0;
                    w_nxt_m_indata = '0;
                end else if (r_wcnt == WLAST) begin
                    w_nxt_state    = ST_DONE;
                    w_nxt_done     = r_gnt;
                    w_nxt_err      = 1'b1;
                    w_nxt_m_wr     = 1'b0;
                    w_nxt_m_indata = '0;
                end else begin
                    w_nxt_wcnt = r_wcnt + 1'b1;
                end
            end

            ST_RD_ISSUE: begin
                w_nxt_state  = ST_RD_CAP;
                w_nxt_m_rd   = 1'b1;
                w_nxt_m_addr = r_k;
            end

            ST_RD_CAP: begin
                w_nxt_rbuf = w_cap;
                if (r_k == KLAST) begin
                    w_nxt_state = ST_DONE;
                    w_nxt_done  = r_gnt;
                    w_nxt_rdata = w_cap;
                end else begin
                    w_nxt_k      = r_k + 2'd1;
                    w_nxt_state  = ST_RD_ISSUE;
                    w_nxt_m_rd   = 1'b1;
                    w_nxt_m_addr = r_k + 2'd1;
                end
            end

            ST_DONE: begin
                w_nxt_state = ST_IDLE;
                w_nxt_last  = r_gnt[1];
                w_nxt_gnt   = 2'b00;
                w_nxt_k     = '0;
            end

            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_gnt   = 2'b00;
                w_nxt_k     = '0;
            end
        endcase
    end

    // State, datapath and output registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_k        <= '0;
            r_wcnt     <= '0;
            r_last     <= 1'b1;
            r_rbuf     <= '0;
            r_gnt      <= 2'b00;
            r_done     <= 2'b00;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_m_wr     <= 1'b0;
            r_m_rd     <= 1'b0;
            r_m_addr   <= '0;
            r_m_indata <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_k        <= w_nxt_k;
            r_wcnt     <= w_nxt_wcnt;
            r_last     <= w_nxt_last;
            r_rbuf     <= w_nxt_rbuf;
            r_gnt      <= w_nxt_gnt;
            r_done     <= w_nxt_done;
            r_err      <= w_nxt_err;
            r_rdata    <= w_nxt_rdata;
            r_m_wr     <= w_nxt_m_wr;
            r_m_rd     <= w_nxt_m_rd;
            r_m_addr   <= w_nxt_m_addr;
            r_m_indata <= w_nxt_m_indata;
        end
    end

    assign gnt0     = r_gnt[0];
    assign gnt1     = r_gnt[1];
    assign done0    = r_done[0];
    assign done1    = r_done[1];
    assign err      = r_err;
    assign rdata    = r_rdata;
    assign m_wr     = r_m_wr;
    assign m_rd     = r_m_rd;
    assign m_addr   = r_m_addr;
    assign m_indata = r_m_indata;

endmodule

// File: tb/tb_mem32_arb_ctrl.sv
// tb_mem32_arb_ctrl: scenario tasks plus a randomized run, checked against a
// transaction-level model of arbitration, write completion and read assembly.
`timescale 1ns/1ps
module tb_mem32_arb_ctrl;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, op0, op1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1, err, m_wr, m_rd;
    logic [1:0]  m_addr;
    logic [31:0] rdata, m_indata;
    logic [7:0]  m_dataout;
    logic        m_valid;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [4];
    int         model_last;

    // Observations filled by run_txn.
    logic [1:0]  obs_gnt, obs_done, obs_after;
    int          obs_len, obs_proto;
    logic        obs_err, obs_timeout, obs_strb_done, obs_first_wr, obs_first_rd;
    logic [31:0] obs_rdata, obs_indata;
    logic [1:0]  obs_addr [16];

    logic [72:0] w_outs;
    assign w_outs = {gnt1, gnt0, done1, done0, err, m_wr, m_rd, m_addr, m_indata, rdata};

    always #5 clk = ~clk;

    // Memory read port: byte appears one cycle after the address.
    always @(posedge clk) m_dataout <= mem[m_addr];

    mem32_arb_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .err(err),
        .m_wr(m_wr), .m_rd(m_rd), .m_addr(m_addr), .m_indata(m_indata),
        .m_dataout(m_dataout), .m_valid(m_valid)
    );

    // Model: expected service length of a write; vmask[c] is m_valid seen at
    // the end of WRITE cycle c, and cycle 1's value never counts.
    function automatic int exp_write_len(input logic [31:0] vmask);
        for (int c = 2; c <= int'(TO); c++) if (vmask[c]) return c;
        return int'(TO);
    endfunction

    function automatic logic exp_write_err(input logic [31:0] vmask);
        for (int c = 2; c <= int'(TO); c++) if (vmask[c]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int exp_pick(input logic [1:0] reqs);
        if (reqs == 2'b01) return 0;
        if (reqs == 2'b10) return 1;
        return 1 - model_last;
    endfunction

    // Drive one transaction from IDLE through DONE and record what happened.
    task automatic run_txn(input logic [1:0] reqs, input logic o0, input logic o1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] vmask, input bit drop);
        req0 = reqs[0]; req1 = reqs[1]; op0 = o0; op1 = o1;
        wdata0 = d0; wdata1 = d1; m_valid = vmask[0];
        obs_proto = 0; obs_len = 0; obs_timeout = 1'b1; obs_done = 2'b00;
        obs_err = 1'b0; obs_rdata = '0; obs_strb_done = 1'b0;
        @(negedge clk);
        obs_gnt      = {gnt1, gnt0};
        obs_indata   = m_indata;
        obs_first_wr = m_wr;
        obs_first_rd = m_rd;
        for (int c = 0; c < 64; c++) begin
            if (done0 || done1) begin
                obs_done      = {done1, done0};
                obs_err       = err;
                obs_rdata     = rdata;
                obs_strb_done = m_wr | m_rd;
                obs_timeout   = 1'b0;
                break;
            end
            obs_len++;
            if (m_wr && m_rd) obs_proto++;
            if ({gnt1, gnt0} != obs_gnt) obs_proto++;
            if (m_indata != obs_indata || m_wr != obs_first_wr || m_rd != obs_first_rd) obs_proto++;
            if (obs_len <= 16) obs_addr[obs_len-1] = m_addr;
            m_valid = (obs_len < 32) ? vmask[obs_len] : 1'b0;
            if (drop && obs_len == 2) begin req0 = 1'b0; req1 = 1'b0; end
            @(negedge clk);
        end
        m_valid = 1'b0;
        if (obs_done[0]) req0 = 1'b0;
        if (obs_done[1]) req1 = 1'b0;
        @(negedge clk);
        obs_after = {gnt1, gnt0} | {done1, done0};
    endtask

    task automatic test_reset();
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
        wdata0 = '0; wdata1 = '0; m_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (w_outs !== '0) begin n_bad++; $display("FAIL reset_async: outputs %h, required 0", w_outs); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        model_last = 1;
        @(negedge clk);
        n_cmp++;
        if (w_outs !== '0) begin n_bad++; $display("FAIL reset_idle: outputs %h, required 0", w_outs); end
    endtask

    task automatic test_tie();
        int seq [3] = '{0, 1, 0};
        for (int r = 0; r < 3; r++) begin
            run_txn(2'b11, 1'b0, 1'b0, 32'h1111_0000 + r, 32'h2222_0000 + r, 32'h0000_0008, 1'b0);
            model_last = seq[r];
            n_cmp++;
            if (obs_gnt !== 2'(1 << seq[r])) begin n_bad++; $display("FAIL tie_gnt[%0d]: got %b, required %b", r, obs_gnt, 2'(1 << seq[r])); end
            n_cmp++;
            if (obs_done !== 2'(1 << seq[r])) begin n_bad++; $display("FAIL tie_done[%0d]: got %b, required %b", r, obs_done, 2'(1 << seq[r])); end
            n_cmp++;
            if (obs_len !== 3) begin n_bad++; $display("FAIL tie_len[%0d]: got %0d, required 3", r, obs_len); end
        end
    endtask

    task automatic test_write_basic();
        run_txn(2'b01, 1'b0, 1'b1, 32'hA1B2C3D4, 32'h0, 32'h0000_0020, 1'b0);
        model_last = 0;
        n_cmp++;
        if (obs_indata !== 32'hA1B2C3D4 || obs_first_wr !== 1'b1 || obs_first_rd !== 1'b0) begin
            n_bad++; $display("FAIL wr_strobe: indata %h wr %b rd %b, required a1b2c3d4 1 0", obs_indata, obs_first_wr, obs_first_rd);
        end
        n_cmp++;
        if (obs_len !== 5 || obs_done !== 2'b01 || obs_err !== 1'b0) begin
            n_bad++; $display("FAIL wr_done: len %0d done %b err %b, required 5 01 0", obs_len, obs_done, obs_err);
        end
        n_cmp++;
        if (obs_proto !== 0 || obs_after !== 2'b00) begin
            n_bad++; $display("FAIL wr_proto: glitches %0d after %b, required 0 00", obs_proto, obs_after);
        end
    endtask

    task automatic test_read_basic();
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;
        run_txn(2'b10, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
        model_last = 1;
        n_cmp++;
        if (obs_gnt !== 2'b10 || obs_len !== 8 || obs_done !== 2'b10) begin
            n_bad++; $display("FAIL rd_shape: gnt %b len %0d done %b, required 10 8 10", obs_gnt, obs_len, obs_done);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs_addr[i] !== 2'(i / 2)) begin n_bad++; $display("FAIL rd_addr[%0d]: got %0d, required %0d", i, obs_addr[i], i / 2); end
        end
        n_cmp++;
        if (obs_rdata !== 32'hA1B2C3D4) begin n_bad++; $display("FAIL rd_data: got %h, required a1b2c3d4", obs_rdata); end
    endtask

    task automatic test_timeout();
        run_txn(2'b01, 1'b0, 1'b0, 32'h5A5A_0F0F, 32'h0, 32'h0, 1'b0);
        model_last = 0;
        n_cmp++;
        if (obs_len !== int'(TO) || obs_err !== 1'b1 || obs_done !== 2'b01) begin
            n_bad++; $display("FAIL timeout: len %0d err %b done %b, required %0d 1 01", obs_len, obs_err, obs_done, TO);
        end
        n_cmp++;
        if (obs_strb_done !== 1'b0) begin n_bad++; $display("FAIL timeout_strobe: m_wr|m_rd in done %b, required 0", obs_strb_done); end
    endtask

    task automatic test_stale_valid();
        run_txn(2'b10, 1'b1, 1'b0, 32'h0, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b0);
        model_last = 1;
        n_cmp++;
        if (obs_len !== 2 || obs_err !== 1'b0 || obs_done !== 2'b10) begin
            n_bad++; $display("FAIL stale_valid: len %0d err %b done %b, required 2 0 10", obs_len, obs_err, obs_done);
        end
    endtask

    task automatic test_reset_mid_read();
        int seen_done;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        req0 = 1'b0; req1 = 1'b1; op1 = 1'b1; m_valid = 1'b0;
        @(negedge clk);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (!(m_rd === 1'b1 && m_addr === 2'd2 && gnt1 === 1'b1)) begin
            n_bad++; $display("FAIL midrd_pos: m_rd %b m_addr %0d gnt1 %b, required 1 2 1", m_rd, m_addr, gnt1);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (w_outs !== '0) begin n_bad++; $display("FAIL midrd_reset: outputs %h, required 0", w_outs); end
        req1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_last = 1;
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done0 || done1 || gnt0 || gnt1) seen_done++;
        end
        n_cmp++;
        if (seen_done !== 0) begin n_bad++; $display("FAIL midrd_nodone: activity cycles %0d, required 0", seen_done); end
        run_txn(2'b10, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
        model_last = 1;
        n_cmp++;
        if (obs_addr[0] !== 2'd0 || obs_len !== 8 || obs_rdata !== 32'h11223344) begin
            n_bad++; $display("FAIL midrd_restart: addr0 %0d len %0d rdata %h, required 0 8 11223344", obs_addr[0], obs_len, obs_rdata);
        end
    endtask

    task automatic test_random();
        logic [1:0]  reqs;
        logic        o0, o1, op;
        logic [31:0] d0, d1, wd, vmask, erdata;
        int          id, elen, mode, bad;
        logic        eerr;
        bit          drop;
        for (int t = 0; t < 40; t++) begin
            reqs = 2'($urandom_range(1, 3));
            o0 = 1'($urandom); o1 = 1'($urandom);
            d0 = $urandom; d1 = $urandom;
            mode = $urandom_range(0, 2);
            if (mode == 0)      vmask = '0;
            else if (mode == 1) vmask = $urandom;
            else                vmask = 32'(1) << $urandom_range(1, 12);
            for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
            drop = ($urandom_range(0, 3) == 0);
            id = exp_pick(reqs);
            op = id ? o1 : o0;
            wd = id ? d1 : d0;
            if (!op) begin
                elen = exp_write_len(vmask); eerr = exp_write_err(vmask); erdata = '0;
            end else begin
                elen = 2 * 4; eerr = 1'b0; erdata = {mem[0], mem[1], mem[2], mem[3]};
            end
            run_txn(reqs, o0, o1, d0, d1, vmask, drop);
            model_last = id;
            n_cmp++;
            if (obs_timeout !== 1'b0) begin n_bad++; $display("FAIL rnd_hang[%0d]: no done within bound", t); end
            n_cmp++;
            if (obs_gnt !== 2'(1 << id) || obs_done !== 2'(1 << id)) begin
                n_bad++; $display("FAIL rnd_gnt[%0d]: gnt %b done %b, required %b", t, obs_gnt, obs_done, 2'(1 << id));
            end
            n_cmp++;
            if (obs_len !== elen || obs_err !== eerr || obs_rdata !== erdata) begin
                n_bad++; $display("FAIL rnd_result[%0d]: len %0d err %b rdata %h, required %0d %b %h", t, obs_len, obs_err, obs_rdata, elen, eerr, erdata);
            end
            n_cmp++;
            if (obs_first_wr !== !op || obs_first_rd !== op || obs_indata !== (op ? 32'h0 : wd)) begin
                n_bad++; $display("FAIL rnd_strobe[%0d]: wr %b rd %b indata %h, required %b %b %h", t, obs_first_wr, obs_first_rd, obs_indata, !op, op, op ? 32'h0 : wd);
            end
            n_cmp++;
            if (obs_proto !== 0 || obs_strb_done !== 1'b0 || obs_after !== 2'b00) begin
                n_bad++; $display("FAIL rnd_proto[%0d]: glitches %0d strobe_in_done %b after %b, required 0 0 00", t, obs_proto, obs_strb_done, obs_after);
            end
            if (op) begin
                bad = 0;
                for (int i = 0; i < 8; i++) if (obs_addr[i] !== 2'(i / 2)) bad++;
                n_cmp++;
                if (bad !== 0) begin n_bad++; $display("FAIL rnd_addr[%0d]: %0d wrong address cycles, required 0", t, bad); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_write_basic();
        test_read_basic();
        test_timeout();
        test_stale_valid();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
